mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Memory-side consumer of the decoder's store-select (sw/sh/sb/swl/swr), mem_read and load-select fields.
//  Sits between the EX/MEM stage and the data-memory port.
//  Stores: drives a request with word address, byte strobes and lane-replicated data.
//  Loads: waits for the response, then extracts/extends bytes and merges lwl/lwr with old rt.
//  Flags misalignment and bus timeout to the pipeline.
// PARAMETERS
//  TIMEOUT  256  cycles waited in WAIT for mem_rsp_valid before bus_err; counter width clog2(TIMEOUT+1)
// PORTS
//  clk           in   1   rising-edge clock
//  resetn        in   1   asynchronous active-low reset
//  in_valid      in   1   access request from pipeline
//  in_ready      out  1   1 only in IDLE
//  in_addr       in   32  effective address (ALU result)
//  in_rt         in   32  rt value: store data / lwl-lwr merge source
//  in_st_pick    in   5   one-hot [0]sw [1]sh [2]sb [3]swl [4]swr
//  in_ld_pick    in   7   one-hot [0]lb [1]lbu [2]lh [3]lhu [4]lwl [5]lwr [6]lw
//  mem_req_valid out  1   request to data memory
//  mem_req_ready in   1   memory accepts request
//  mem_wr        out  1   1 store, 0 load
//  mem_addr      out  32  {in_addr[31:2],2'b00}
//  mem_wstrb     out  4   byte enables (0000 for loads)
//  mem_wdata     out  32  lane-placed store data
//  mem_rsp_valid in   1   load data valid (ignored outside WAIT)
//  mem_rdata     in   32  load word
//  out_valid     out  1   access complete; held until out_ready
//  out_ready     in   1   pipeline consumes result
//  out_data      out  32  load result (0 for stores/errors)
//  addr_err      out  1   misaligned or illegal pick, valid with out_valid
//  bus_err       out  1   timeout, valid with out_valid
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except in_ready=1; timeout counter 0. Reset mid-access aborts it.
//  FSM:
//   IDLE->REQ on in_valid; request fields registered.
//   IDLE->DONE directly with addr_err=1 (no memory request) if:
//     lh/lhu/sh with addr[0]!=0; lw/sw with addr[1:0]!=0;
//     in_st_pick|in_ld_pick not exactly one-hot.
//   REQ: mem_req_valid=1, outputs stable until mem_req_ready.
//     Store -> DONE. Load -> WAIT, counter cleared.
//   WAIT: mem_rsp_valid -> DONE with formatted data; counter==TIMEOUT-1 -> DONE with bus_err=1.
//   DONE: out_valid=1 until out_ready, then IDLE.
//  Latency with zero-wait memory:
//   accept cycle 0; REQ cycle 1; store out_valid cycle 2;
//   load rsp cycle 2 -> out_valid cycle 3.
//  Store lanes (a=addr[1:0], little-endian):
//   sw: 1111, rt
//   sh: a[1]?1100:0011, {2{rt[15:0]}}
//   sb: 0001<<a, {4{rt[7:0]}}
//   swl: a=0..3 -> 0001/0011/0111/1111, rt>>(8*(3-a))
//   swr: a=0..3 -> 1111/1110/1100/1000, rt<<(8*a)
//  Load format (m=mem_rdata):
//   lb/lbu: byte a, sign/zero extended
//   lh/lhu: half a[1], sign/zero extended
//   lw: m
//   lwl: {m[8a+7:0], rt[23-8a:0]} (a=3 -> m)
//   lwr: {rt[31:32-8a], m[31:8a]} (a=0 -> m)
// TESTING
//  sb addr=0x1003 rt=0x000000AB -> mem_addr 0x1000, wstrb 1000, wdata 0xABABABAB, out_valid cycle 2.
//  lb addr=0x2001, rdata 0x1234F600 -> out_data 0xFFFFFFF6; same with lbu -> 0x000000F6.
//  lwl addr=1 rt=0xAABBCCDD rdata 0x11223344 -> 0x3344CCDD; lwr addr=1 -> 0xAA112233.
//  lw addr=0x2002 -> addr_err=1, mem_req_valid never asserted; sh addr=0x1 -> addr_err=1.
//  Load, mem_req_ready low 5 cycles then no rsp for TIMEOUT cycles -> bus_err=1, out_data 0.
//  Backpressure: out_ready low 3 cycles -> out_valid/out_data stable, in_ready 0; resetn low in WAIT -> IDLE next cycle.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-side load/store unit: places store data on byte lanes, formats load data
// (extension, lwl/lwr merge), and reports misalignment or bus timeout to the pipeline.
module mem_access_unit #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_rt,
    input  logic [4:0]  in_st_pick,
    input  logic [6:0]  in_ld_pick,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        addr_err,
    output logic        bus_err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   rt_q, rt_d;
    logic [4:0]    st_q, st_d;
    logic [6:0]    ld_q, ld_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   data_q, data_d;
    logic          aerr_q, aerr_d;
    logic          berr_q, berr_d;
    logic          is_store;
    logic          in_req;

    function automatic logic onehot12(input logic [11:0] v);
        return (v != 12'd0) && ((v & (v - 12'd1)) == 12'd0);
    endfunction

    function automatic logic misaligned(input logic [4:0] st, input logic [6:0] ld,
                                        input logic [1:0] a);
        return ((st[1] | ld[2] | ld[3]) & a[0]) | ((st[0] | ld[6]) & (a != 2'b00));
    endfunction

    function automatic logic [3:0] store_strb(input logic [4:0] st, input logic [1:0] a);
        logic [3:0] s;
        s = 4'b0000;
        if (st[0])      s = 4'b1111;
        else if (st[1]) s = a[1] ? 4'b1100 : 4'b0011;
        else if (st[2]) s = 4'b0001 << a;
        else if (st[3]) s = 4'b1111 >> (~a);
        else if (st[4]) s = 4'b1111 << a;
        return s;
    endfunction

    function automatic logic [31:0] store_data(input logic [4:0] st, input logic [1:0] a,
                                               input logic [31:0] rt);
        logic [31:0] d;
        d = 32'd0;
        if (st[0])      d = rt;
        else if (st[1]) d = {2{rt[15:0]}};
        else if (st[2]) d = {4{rt[7:0]}};
        else if (st[3]) d = rt >> {~a, 3'b000};
        else if (st[4]) d = rt << {a, 3'b000};
        return d;
    endfunction

    // lwl/lwr keep the rt bytes that the unaligned memory word does not cover
    function automatic logic [31:0] load_fmt(input logic [6:0] ld, input logic [1:0] a,
                                             input logic [31:0] m, input logic [31:0] rt);
        logic [4:0]  sh;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        sh = {a, 3'b000};
        b  = 8'(m >> sh);
        h  = a[1] ? m[31:16] : m[15:0];
        r  = m;
        if (ld[0])      r = {{24{b[7]}}, b};
        else if (ld[1]) r = {24'd0, b};
        else if (ld[2]) r = {{16{h[15]}}, h};
        else if (ld[3]) r = {16'd0, h};
        else if (ld[4]) r = (m << {~a, 3'b000}) | (rt & (32'h00FF_FFFF >> sh));
        else if (ld[5]) r = (m >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
        return r;
    endfunction

    assign is_store = |st_q;
    assign in_req   = (state_q == S_REQ);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rt_d    = rt_q;
        st_d    = st_q;
        ld_d    = ld_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        aerr_d  = aerr_q;
        berr_d  = berr_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    addr_d = in_addr;
                    rt_d   = in_rt;
                    st_d   = in_st_pick;
                    ld_d   = in_ld_pick;
                    if (!onehot12({in_st_pick, in_ld_pick}) ||
                        misaligned(in_st_pick, in_ld_pick, in_addr[1:0])) begin
                        aerr_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = is_store ? S_DONE : S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    data_d  = load_fmt(ld_q, addr_q[1:0], mem_rdata, rt_q);
                    state_d = S_DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    berr_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    data_d  = 32'd0;
                    aerr_d  = 1'b0;
                    berr_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
            rt_q    <= 32'd0;
            st_q    <= 5'd0;
            ld_q    <= 7'd0;
            cnt_q   <= '0;
            data_q  <= 32'd0;
            aerr_q  <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rt_q    <= rt_d;
            st_q    <= st_d;
            ld_q    <= ld_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            aerr_q  <= aerr_d;
            berr_q  <= berr_d;
        end
    end

    assign in_ready      = (state_q == S_IDLE);
    assign mem_req_valid = in_req;
    assign mem_wr        = in_req & is_store;
    assign mem_addr      = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_wstrb     = (in_req & is_store) ? store_strb(st_q, addr_q[1:0]) : 4'b0000;
    assign mem_wdata     = (in_req & is_store) ? store_data(st_q, addr_q[1:0], rt_q) : 32'd0;
    assign out_valid     = (state_q == S_DONE);
    assign out_data      = data_q;
    assign addr_err      = aerr_q;
    assign bus_err       = berr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vectors, timeout, backpressure, reset abort and
// randomized accesses checked against a byte-lane reference model.
module tb_mem_access_unit;
    localparam int TO = 256;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid, in_ready;
    logic [31:0] in_addr, in_rt;
    logic [4:0]  in_st_pick;
    logic [6:0]  in_ld_pick;
    logic        mem_req_valid, mem_req_ready, mem_wr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        out_valid, out_ready, addr_err, bus_err;
    logic [31:0] out_data;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        bit          got;
        bit          saw_req;
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] data;
        logic        aerr;
        logic        berr;
        int          lat;
        bit          ov_unstable;
        bit          req_unstable;
        bit          inrdy_bad;
        bit          idle_ok;
    } res_t;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_rt(in_rt),
        .in_st_pick(in_st_pick), .in_ld_pick(in_ld_pick),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .addr_err(addr_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    // Reference model: works on byte lanes following the access rules directly.
    function automatic void model(input logic [4:0] st, input logic [6:0] ld,
                                  input logic [31:0] addr, input logic [31:0] rt,
                                  input logic [31:0] m, output bit err, output bit store,
                                  output logic [3:0] strb, output logic [31:0] wdata,
                                  output logic [31:0] data);
        int a;
        byte unsigned mb[4], rb[4], wb[4], db[4];
        a = int'(addr[1:0]);
        for (int i = 0; i < 4; i++) begin
            mb[i] = m[8*i +: 8];
            rb[i] = rt[8*i +: 8];
            wb[i] = 8'h00;
            db[i] = 8'h00;
        end
        err = ($countones({st, ld}) != 1) || ((ld[2] || ld[3] || st[1]) && addr[0])
              || ((ld[6] || st[0]) && a != 0);
        store = (st != 5'd0);
        strb = 4'b0000; wdata = 32'd0; data = 32'd0;
        if (err) return;
        if (store) begin
            for (int i = 0; i < 4; i++) begin
                if (st[0])      begin strb[i] = 1'b1;          wb[i] = rb[i];     end
                else if (st[1]) begin strb[i] = (i/2 == a/2);  wb[i] = rb[i%2];   end
                else if (st[2]) begin strb[i] = (i == a);      wb[i] = rb[0];     end
                else if (st[3]) begin strb[i] = (i <= a);      wb[i] = (i <= a) ? rb[i+3-a] : 8'h00; end
                else            begin strb[i] = (i >= a);      wb[i] = (i >= a) ? rb[i-a] : 8'h00;   end
            end
            wdata = {wb[3], wb[2], wb[1], wb[0]};
        end else if (ld[0] || ld[1]) begin
            data = {24'd0, mb[a]};
            if (ld[0] && mb[a][7]) data = data | 32'hFFFF_FF00;
        end else if (ld[2] || ld[3]) begin
            data = {16'd0, mb[(a/2)*2+1], mb[(a/2)*2]};
            if (ld[2] && data[15]) data = data | 32'hFFFF_0000;
        end else if (ld[6]) begin
            data = m;
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (ld[4]) db[j] = (j >= 3 - a) ? mb[j-(3-a)] : rb[j];
                else       db[j] = (j <= 3 - a) ? mb[j+a]     : rb[j];
            end
            data = {db[3], db[2], db[1], db[0]};
        end
    endfunction

    // Plays pipeline and memory for one access; rsp_wait < 0 means memory never answers.
    task automatic drive_access(input logic [4:0] st, input logic [6:0] ld,
                                input logic [31:0] addr, input logic [31:0] rt,
                                input logic [31:0] rdata, input int req_wait,
                                input int rsp_wait, input int out_wait, input bit noise,
                                output res_t r);
        int cyc = 0, reqcnt = 0, wcnt = 0, ovcnt = 0;
        bit hs = 0, in_wait = 0, done = 0;
        r = '{default: 0};
        @(negedge clk);
        in_valid = 1'b1; in_addr = addr; in_rt = rt; in_st_pick = st; in_ld_pick = ld;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; out_ready = 1'b0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            in_valid = 1'b0; in_addr = $urandom; in_rt = $urandom;
            in_st_pick = 5'($urandom); in_ld_pick = 7'($urandom);
            if (hs) begin hs = 0; in_wait = (st == 5'd0); wcnt = 0; end
            if (out_valid) begin
                ovcnt++;
                if (ovcnt == 1) begin
                    r.got = 1; r.lat = cyc; r.data = out_data; r.aerr = addr_err; r.berr = bus_err;
                end else if (out_data !== r.data || addr_err !== r.aerr || bus_err !== r.berr) begin
                    r.ov_unstable = 1;
                end
                if (in_ready !== 1'b0) r.inrdy_bad = 1;
                in_wait = 0; mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
                out_ready = (ovcnt > out_wait);
                if (out_ready) done = 1;
            end else begin
                if (mem_req_valid) begin
                    reqcnt++;
                    if (reqcnt == 1) begin
                        r.saw_req = 1; r.addr = mem_addr; r.wr = mem_wr;
                        r.strb = mem_wstrb; r.wdata = mem_wdata;
                    end else if (mem_addr !== r.addr || mem_wr !== r.wr ||
                                 mem_wstrb !== r.strb || mem_wdata !== r.wdata) begin
                        r.req_unstable = 1;
                    end
                    mem_req_ready = (reqcnt > req_wait);
                    hs = mem_req_ready;
                end else begin
                    mem_req_ready = 1'b0;
                end
                if (in_wait) begin
                    mem_rsp_valid = (rsp_wait >= 0 && wcnt == rsp_wait);
                    mem_rdata = mem_rsp_valid ? rdata : $urandom;
                    if (mem_rsp_valid) in_wait = 0;
                    wcnt++;
                end else begin
                    mem_rsp_valid = noise && ($urandom_range(0, 1) == 1);
                    mem_rdata = $urandom;
                end
            end
        end
        @(negedge clk);
        out_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        r.idle_ok = (out_valid === 1'b0 && in_ready === 1'b1);
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, mem_req_valid, mem_wr} !== 4'b1000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 1000", {in_ready, out_valid, mem_req_valid, mem_wr});
        end
        n_cmp++;
        if ({mem_addr, mem_wstrb, mem_wdata} !== 68'd0) begin
            n_fail++; $display("FAIL reset_mem: got %h want 0", {mem_addr, mem_wstrb, mem_wdata});
        end
        resetn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_data, addr_err, bus_err} !== {1'b1, 34'd0}) begin
            n_fail++; $display("FAIL reset_out: got %h want %h", {in_ready, out_data, addr_err, bus_err}, {1'b1, 34'd0});
        end
    endtask

    task automatic test_directed;
        res_t r;
        drive_access(5'b00100, 7'd0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 0, 0, 0, r);
        n_cmp++;
        if ({r.saw_req, r.wr, r.addr, r.strb, r.wdata} !== {2'b11, 32'h1000, 4'b1000, 32'hABAB_ABAB}) begin
            n_fail++; $display("FAIL sb_req: got addr %h strb %b wdata %h", r.addr, r.strb, r.wdata);
        end
        n_cmp++;
        if (r.lat !== 2 || r.data !== 32'd0) begin
            n_fail++; $display("FAIL sb_done: got lat %0d data %h want 2/0", r.lat, r.data);
        end
        drive_access(5'd0, 7'b0000001, 32'h0000_2001, 32'h0, 32'h1234_F600, 0, 0, 0, 0, r);
        n_cmp++;
        if (r.data !== 32'hFFFF_FFF6 || r.lat !== 3 || r.wr !== 1'b0 || r.strb !== 4'b0000) begin
            n_fail++; $display("FAIL lb: got data %h lat %0d want FFFFFFF6/3", r.data, r.lat);
        end
        drive_access(5'd0, 7'b0000010, 32'h0000_2001, 32'h0, 32'h1234_F600, 0, 0, 0, 0, r);
        n_cmp++;
        if (r.data !== 32'h0000_00F6) begin
            n_fail++; $display("FAIL lbu: got %h want 000000F6", r.data);
        end
        drive_access(5'd0, 7'b0010000, 32'h1, 32'hAABB_CCDD, 32'h1122_3344, 0, 0, 0, 0, r);
        n_cmp++;
        if (r.data !== 32'h3344_CCDD) begin
            n_fail++; $display("FAIL lwl: got %h want 3344CCDD", r.data);
        end
        drive_access(5'd0, 7'b0100000, 32'h1, 32'hAABB_CCDD, 32'h1122_3344, 0, 0, 0, 0, r);
        n_cmp++;
        if (r.data !== 32'hAA11_2233) begin
            n_fail++; $display("FAIL lwr: got %h want AA112233", r.data);
        end
        drive_access(5'd0, 7'b1000000, 32'h0000_2002, 32'h0, 32'h0, 0, 0, 0, 0, r);
        n_cmp++;
        if (r.aerr !== 1'b1 || r.saw_req !== 1'b0 || r.lat !== 1 || r.data !== 32'd0) begin
            n_fail++; $display("FAIL lw_misalign: got aerr %b req %b lat %0d", r.aerr, r.saw_req, r.lat);
        end
        drive_access(5'b00010, 7'd0, 32'h1, 32'h1234, 32'h0, 0, 0, 0, 0, r);
        n_cmp++;
        if (r.aerr !== 1'b1 || r.saw_req !== 1'b0) begin
            n_fail++; $display("FAIL sh_misalign: got aerr %b req %b want 1/0", r.aerr, r.saw_req);
        end
        drive_access(5'b00001, 7'b1000000, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, r);
        n_cmp++;
        if (r.aerr !== 1'b1 || r.saw_req !== 1'b0) begin
            n_fail++; $display("FAIL two_picks: got aerr %b req %b want 1/0", r.aerr, r.saw_req);
        end
    endtask

    task automatic test_timeout;
        res_t r;
        drive_access(5'd0, 7'b1000000, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 5, -1, 0, 0, r);
        n_cmp++;
        if (r.got !== 1'b1 || r.berr !== 1'b1 || r.aerr !== 1'b0 || r.data !== 32'd0) begin
            n_fail++; $display("FAIL timeout_flags: got berr %b aerr %b data %h", r.berr, r.aerr, r.data);
        end
        n_cmp++;
        if (r.lat !== TO + 7 || r.req_unstable !== 1'b0) begin
            n_fail++; $display("FAIL timeout_lat: got %0d want %0d", r.lat, TO + 7);
        end
        drive_access(5'd0, 7'b1000000, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 0, TO - 1, 0, 0, r);
        n_cmp++;
        if (r.berr !== 1'b0 || r.data !== 32'hDEAD_BEEF || r.lat !== TO + 2) begin
            n_fail++; $display("FAIL late_rsp: got berr %b data %h lat %0d", r.berr, r.data, r.lat);
        end
    endtask

    task automatic test_backpressure;
        res_t r;
        drive_access(5'd0, 7'b0001000, 32'h0000_0102, 32'h0, 32'h8765_4321, 1, 2, 3, 0, r);
        n_cmp++;
        if (r.ov_unstable !== 1'b0 || r.inrdy_bad !== 1'b0 || r.idle_ok !== 1'b1) begin
            n_fail++; $display("FAIL bp_stable: got unstable %b inrdy %b idle %b", r.ov_unstable, r.inrdy_bad, r.idle_ok);
        end
        n_cmp++;
        if (r.data !== 32'h0000_8765 || r.lat !== 6) begin
            n_fail++; $display("FAIL bp_data: got %h lat %0d want 00008765/6", r.data, r.lat);
        end
    endtask

    task automatic test_reset_wait;
        res_t r;
        @(negedge clk);
        in_valid = 1'b1; in_st_pick = 5'd0; in_ld_pick = 7'b1000000; in_addr = 32'h40;
        mem_req_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        mem_req_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0 || mem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_wait_pre: got in_ready %b req %b", in_ready, mem_req_valid);
        end
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_wait_idle: got in_ready %b out_valid %b", in_ready, out_valid);
        end
        mem_rsp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_wait_stray_rsp: got out_valid %b want 0", out_valid);
        end
        drive_access(5'd0, 7'b1000000, 32'h44, 32'h0, 32'h0BAD_F00D, 0, 1, 0, 0, r);
        n_cmp++;
        if (r.data !== 32'h0BAD_F00D || r.lat !== 4) begin
            n_fail++; $display("FAIL rst_wait_after: got %h lat %0d", r.data, r.lat);
        end
    endtask

    task automatic test_random;
        res_t r;
        bit e, s;
        logic [3:0]  es;
        logic [31:0] ew, ed, addr, rt, m;
        logic [11:0] pick;
        int rq, rs, ow, lat;
        for (int n = 0; n < 150; n++) begin
            pick = 12'd1 << $urandom_range(0, 11);
            if ($urandom_range(0, 9) == 0) pick = 12'($urandom);
            addr = $urandom; rt = $urandom; m = $urandom;
            rq = $urandom_range(0, 3); rs = $urandom_range(0, 4); ow = $urandom_range(0, 2);
            model(pick[11:7], pick[6:0], addr, rt, m, e, s, es, ew, ed);
            drive_access(pick[11:7], pick[6:0], addr, rt, m, rq, rs, ow, 1, r);
            lat = e ? 1 : (s ? 2 + rq : 3 + rq + rs);
            n_cmp++;
            if (r.got !== 1'b1 || r.aerr !== e || r.berr !== 1'b0 || r.data !== ed) begin
                n_fail++;
                $display("FAIL rnd_result[%0d]: pick %b addr %h got data %h aerr %b berr %b want %h/%b/0",
                         n, pick, addr, r.data, r.aerr, r.berr, ed, e);
            end
            n_cmp++;
            if (r.lat !== lat || r.saw_req !== !e || r.ov_unstable || r.idle_ok !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd_timing[%0d]: got lat %0d req %b want %0d/%b", n, r.lat, r.saw_req, lat, !e);
            end
            if (!e) begin
                n_cmp++;
                if (r.addr !== {addr[31:2], 2'b00} || r.wr !== s || r.strb !== es ||
                    r.wdata !== ew || r.req_unstable) begin
                    n_fail++;
                    $display("FAIL rnd_req[%0d]: pick %b got %h %b %b %h want %h %b %b %h", n, pick,
                             r.addr, r.wr, r.strb, r.wdata, {addr[31:2], 2'b00}, s, es, ew);
                end
            end
        end
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_addr = 32'd0; in_rt = 32'd0;
        in_st_pick = 5'd0; in_ld_pick = 7'd0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rdata = 32'd0; out_ready = 1'b0;
        test_reset();
        test_directed();
        test_timeout();
        test_backpressure();
        test_reset_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
